// File: rtl/relu_argmax_pkg.sv
// -----------------------------------------------------------------------------
// relu_argmax_pkg
// Shared definitions for the ReLU + argmax output stage.
//   - float8 field layout: sign[7], exponent[6:3], mantissa[2:0] in
//     sign-magnitude form. No NaN or Inf encodings exist.
//   - FSM state encoding used by relu_argmax.
// -----------------------------------------------------------------------------
package relu_argmax_pkg;

    localparam int SIGN_BIT = 7;
    localparam int EXP_MSB  = 6;
    localparam int EXP_LSB  = 3;
    localparam int MAN_W    = 3;

    localparam logic [7:0] FLOAT8_ZERO = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/float8_relu.sv
// -----------------------------------------------------------------------------
// float8_relu
// Combinational ReLU on one float8 value. Any value with the sign bit set,
// including negative zero (0x80), becomes 0x00; everything else passes through.
//   din  : float8 input
//   dout : rectified float8 output
// -----------------------------------------------------------------------------
module float8_relu
    import relu_argmax_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    function automatic logic [7:0] relu8(input logic [7:0] x);
        return x[SIGN_BIT] ? FLOAT8_ZERO : x;
    endfunction

    assign dout = relu8(din);

endmodule

// File: rtl/relu_argmax.sv
// -----------------------------------------------------------------------------
// relu_argmax
// Rectifies a NUM_LANES-wide float8 vector one lane per enabled cycle and
// tracks the largest rectified value among lanes 0..CLASS_CNT-1.
//
// Build option: define RELU_ARGMAX_EN to include the argmax comparator and
// max registers. Without it class_idx and max_value are constant zero and
// the ReLU path, timing and handshake are unchanged.
//
// Ports
//   clk          rising-edge clock
//   iRst_n       asynchronous active-low reset
//   ena          clock enable; low freezes all state
//   start        one-cycle job request, accepted only in IDLE
//   data_in      float8 vector, lane k = bits [8k+7:8k]
//   overflow_in  upstream overflow flag, latched with data_in
//   relu_out     rectified vector
//   class_idx    index of the maximum candidate lane
//   max_value    rectified value of the maximum candidate lane
//   busy         high in SCAN and DONE
//   done         one-cycle completion pulse
//   overflow     overflow flag of the current job
//
// Timing: start sampled at edge T gives done high after edge T+NUM_LANES+1.
// The extra cycle comes from a one-stage pipeline between lane selection and
// result commit, which keeps the wide lane mux off the compare path.
// -----------------------------------------------------------------------------
module relu_argmax
    import relu_argmax_pkg::*;
#(
    parameter int NUM_LANES = 128,
    parameter int CLASS_CNT = 10,
    parameter int IDX_W     = 7
)(
    input  logic                   clk,
    input  logic                   iRst_n,
    input  logic                   ena,
    input  logic                   start,
    input  logic [NUM_LANES*8-1:0] data_in,
    input  logic                   overflow_in,
    output logic [NUM_LANES*8-1:0] relu_out,
    output logic [IDX_W-1:0]       class_idx,
    output logic [7:0]             max_value,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(NUM_LANES - 1);

    if (CLASS_CNT < 1 || CLASS_CNT > NUM_LANES) begin : g_bad_class_cnt
        $error("relu_argmax: CLASS_CNT must be in 1..NUM_LANES");
    end

    state_t                 state;
    logic [IDX_W-1:0]       cnt;
    logic                   drain;      // all lanes issued, waiting for last commit
    logic [NUM_LANES*8-1:0] data_buf;

    logic [7:0]             lane_sel;
    logic [7:0]             lane_relu;

    logic                   vld_p1;
    logic [IDX_W-1:0]       lane_p1;
    logic [7:0]             relu_p1;

    // ---- stage p0: select lane cnt from the job buffer and rectify ----------
    assign lane_sel = data_buf[{cnt, 3'b000} +: 8];

    float8_relu u_relu (
        .din  (lane_sel),
        .dout (lane_relu)
    );

    // Data-only registers: their contents are qualified by state/vld_p1, so
    // they carry no reset.
    always_ff @(posedge clk) begin
        if (ena) begin
            if (state == IDLE && start) begin
                data_buf <= data_in;
            end
            // ---- stage p1: rectified lane registered with its index -------
            if (state == SCAN && !drain) begin
                lane_p1 <= cnt;
                relu_p1 <= lane_relu;
            end
        end
    end

    // Control FSM plus relu_out commit.
    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            drain    <= 1'b0;
            vld_p1   <= 1'b0;
            relu_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else if (ena) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    vld_p1 <= 1'b0;
                    if (start) begin
                        overflow <= overflow_in;
                        cnt      <= '0;
                        drain    <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    vld_p1 <= !drain;
                    if (!drain) begin
                        if (cnt == LAST_LANE) begin
                            drain <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    // ---- stage p2: commit lane result ----------------------
                    if (vld_p1) begin
                        relu_out[{lane_p1, 3'b000} +: 8] <= relu_p1;
                        if (lane_p1 == LAST_LANE) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    vld_p1 <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    vld_p1 <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

`ifdef RELU_ARGMAX_EN
    localparam logic [IDX_W:0] CAND_LIM = (IDX_W + 1)'(CLASS_CNT);

    // Strict greater-than keeps the lowest index on ties. Rectified values
    // are never negative, so bits [6:0] order them as unsigned magnitudes.
    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            max_value <= FLOAT8_ZERO;
            class_idx <= '0;
        end else if (ena) begin
            if (state == IDLE && start) begin
                max_value <= FLOAT8_ZERO;
                class_idx <= '0;
            end else if (state == SCAN && vld_p1 &&
                         ({1'b0, lane_p1} < CAND_LIM) &&
                         (relu_p1[6:0] > max_value[6:0])) begin
                max_value <= relu_p1;
                class_idx <= lane_p1;
            end
        end
    end
`else
    assign class_idx = '0;
    assign max_value = FLOAT8_ZERO;
`endif

endmodule

// File: tb/tb_relu_argmax.sv
module tb_relu_argmax;
    import relu_argmax_pkg::*;

    localparam int NL = 128;
    localparam int CC = 10;
    localparam int IW = 7;
    localparam int VW = NL * 8;

`ifdef RELU_ARGMAX_EN
    localparam bit AM = 1'b1;
`else
    localparam bit AM = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          iRst_n = 1'b0;
    logic          ena = 1'b1;
    logic          start = 1'b0;
    logic [VW-1:0] data_in = '0;
    logic          overflow_in = 1'b0;
    logic [VW-1:0] relu_out;
    logic [IW-1:0] class_idx;
    logic [7:0]    max_value;
    logic          busy;
    logic          done;
    logic          overflow;

    relu_argmax #(.NUM_LANES(NL), .CLASS_CNT(CC), .IDX_W(IW)) dut (
        .clk         (clk),
        .iRst_n      (iRst_n),
        .ena         (ena),
        .start       (start),
        .data_in     (data_in),
        .overflow_in (overflow_in),
        .relu_out    (relu_out),
        .class_idx   (class_idx),
        .max_value   (max_value),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [VW-1:0] relu;
        int            idx;
        int            mx;
        int            ovf;
        int            t0;
        int            lat;
        string         name;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] req);
        int bad;
        bad = -1;
        for (int k = NL - 1; k >= 0; k--)
            if (act[8*k +: 8] !== req[8*k +: 8]) bad = k;
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s lane=%0d actual=0x%0h required=0x%0h", nm, bad,
                     act[8*bad +: 8], req[8*bad +: 8]);
        end
    endtask

    function automatic logic [VW-1:0] relu_model(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        for (int k = 0; k < NL; k++)
            r[8*k +: 8] = v[8*k + 7] ? 8'h00 : v[8*k +: 8];
        return r;
    endfunction

    // Scoreboard monitor: every done pulse pops one expected job.
    always @(negedge clk) begin
        if (iRst_n && done) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, "_latency"}, cyc - e.t0, e.lat);
                chk({e.name, "_class_idx"}, class_idx, e.idx);
                chk({e.name, "_max_value"}, max_value, e.mx);
                chk({e.name, "_overflow"}, overflow, e.ovf);
                chk({e.name, "_busy_in_done"}, busy, 1);
                chk_vec({e.name, "_relu_out"}, relu_out, e.relu);
            end
        end
    end

    task automatic issue(input logic [VW-1:0] v, input logic ovf, input int ei,
                         input int em, input int lat, input string nm);
        exp_t e;
        @(negedge clk);
        data_in     = v;
        overflow_in = ovf;
        start       = 1'b1;
        e.relu = relu_model(v);
        e.idx  = AM ? ei : 0;
        e.mx   = AM ? em : 0;
        e.ovf  = ovf;
        e.t0   = cyc + 1;
        e.lat  = lat;
        e.name = nm;
        q.push_back(e);
        @(negedge clk);
        start       = 1'b0;
        overflow_in = 1'b0;
        data_in     = ~v;           // must not disturb the running job
        chk({nm, "_busy_after_start"}, busy, 1);
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_done required=done", nm);
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    logic [VW-1:0] v1, vneg, v3;
    logic [7:0]    l1 [10];

    initial begin
        l1 = '{8'h10, 8'h38, 8'h22, 8'hB8, 8'h38, 8'h05, 8'h80, 8'h30, 8'h11, 8'h37};
        v1 = {NL{8'h7F}};
        for (int k = 0; k < 10; k++) v1[8*k +: 8] = l1[k];
        vneg = {NL{8'hC5}};
        // lane 5 is a large negative, lane 9 the largest candidate, lane 10 larger but excluded
        v3 = {NL{8'h01}};
        v3[8*5 +: 8]  = 8'hFF;
        v3[8*9 +: 8]  = 8'h7E;
        v3[8*10 +: 8] = 8'h7F;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_relu_zero", (relu_out == '0), 1);
        chk("rst_class_idx", class_idx, 0);
        chk("rst_max_value", max_value, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        iRst_n = 1'b1;
        @(negedge clk);

        // Reference vector: ties on 0x38 keep lane 1, 0x7F lanes are not candidates
        issue(v1, 1'b0, 1, 8'h38, 129, "v1");
        wait_drain("v1");
        chk("v1_relu_lane3", relu_out[8*3 +: 8], 8'h00);
        chk("v1_relu_lane6", relu_out[8*6 +: 8], 8'h00);
        chk("v1_relu_lane127", relu_out[8*127 +: 8], 8'h7F);
        repeat (5) @(negedge clk);
        chk("v1_hold_class_idx", class_idx, AM ? 1 : 0);
        chk("v1_idle_busy", busy, 0);

        // All negative
        issue(vneg, 1'b0, 0, 8'h00, 129, "allneg");
        wait_drain("allneg");

        // Max at the last candidate lane
        issue(v3, 1'b0, 9, 8'h7E, 129, "v3");
        wait_drain("v3");

        // start while busy and in DONE must be ignored
        begin
            int n;
            issue(v1, 1'b0, 1, 8'h38, 129, "restart");
            repeat (3) @(negedge clk);
            start = 1'b1; data_in = vneg;
            @(negedge clk);
            start = 1'b0;
            n = 0;
            while (!done && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk("restart_done_seen", done, 1);
            start = 1'b1; data_in = vneg;
            @(negedge clk);
            start = 1'b0;
            repeat (200) @(negedge clk);
            chk("restart_idle_busy", busy, 0);
            chk("restart_kept_max", max_value, AM ? 8'h38 : 0);
            chk_vec("restart_kept_relu", relu_out, relu_model(v1));
        end

        // ena low for 20 cycles mid-scan
        issue(v1, 1'b0, 1, 8'h38, 149, "ena_pause");
        repeat (29) @(negedge clk);
        ena = 1'b0;
        repeat (20) @(negedge clk);
        ena = 1'b1;
        wait_drain("ena_pause");

        // Asynchronous reset mid-scan aborts the job
        issue(v1, 1'b1, 1, 8'h38, 129, "aborted");
        repeat (59) @(negedge clk);
        #2 iRst_n = 1'b0;
        #1;
        chk("abort_relu_zero", (relu_out == '0), 1);
        chk("abort_class_idx", class_idx, 0);
        chk("abort_max_value", max_value, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_overflow", overflow, 0);
        q.delete();
        @(negedge clk);
        iRst_n = 1'b1;
        repeat (150) @(negedge clk);
        issue(v1, 1'b0, 1, 8'h38, 129, "after_rst");
        wait_drain("after_rst");

        // Overflow is per job
        issue(v1, 1'b1, 1, 8'h38, 129, "ovf1");
        repeat (50) @(negedge clk);
        chk("ovf1_mid_scan", overflow, 1);
        wait_drain("ovf1");
        chk("ovf1_after_done", overflow, 1);
        issue(v3, 1'b0, 9, 8'h7E, 129, "ovf0");
        chk("ovf0_after_start", overflow, 0);
        wait_drain("ovf0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
